// File: rtl/riot_pkg.sv
// riot_pkg: shared constants for the riot RAM/I/O/timer responder.
//   - register offsets for the port block (A[1:0] when RS_N=1, A[2]=0)
//   - address bit positions that steer timer accesses
//   - prescale interval table, expressed as the reload value (interval-1)
package riot_pkg;

    // Port register offsets within the register space
    localparam logic [1:0] ORA  = 2'd0;
    localparam logic [1:0] DDRA = 2'd1;
    localparam logic [1:0] ORB  = 2'd2;
    localparam logic [1:0] DDRB = 2'd3;

    // Address bits that steer timer accesses
    localparam int TIMER_BIT = 2;   // A[2]: 1 selects the timer block
    localparam int FLAG_BIT  = 0;   // A[0] on timer reads: 1 = flag, 0 = count
    localparam int IE_BIT    = 3;   // A[3]: interrupt enable written on timer access

    // Select code loaded at reset (the /1024 interval)
    localparam logic [1:0] SEL_RESET = 2'd3;

    // Timer state: TFLAG=0 counts through the prescaler, TFLAG=1 runs every cycle
    typedef enum logic {
        PRESCALED = 1'b0,
        FAST      = 1'b1
    } timer_state_e;

    // Interval table 1/8/64/1024, returned as interval-1 for the prescaler
    function automatic logic [9:0] prescale_reload(input logic [1:0] sel);
        case (sel)
            2'd0:    prescale_reload = 10'd0;
            2'd1:    prescale_reload = 10'd7;
            2'd2:    prescale_reload = 10'd63;
            default: prescale_reload = 10'd1023;
        endcase
    endfunction

endpackage

// File: rtl/riot_timer.sv
// riot_timer: prescaled 8-bit interval timer with underflow flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr         : timer write strobe (loads count, interval, enable; clears flag)
//   rd         : timer count read strobe (clears flag, reloads enable)
//   din        : value loaded into the count on a write
//   sel        : interval select (1/8/64/1024)
//   ie         : interrupt enable value taken on a write or count read
//   count      : current timer value
//   flag       : underflow flag (TFLAG)
//   ien        : interrupt enable (TIE)
module riot_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] din,
    input  logic [1:0] sel,
    input  logic       ie,
    output logic [7:0] count,
    output logic       flag,
    output logic       ien
);
    import riot_pkg::*;

    timer_state_e state;
    logic [9:0]   pre;
    logic [1:0]   sel_q;

    // A write overrides everything. Otherwise the timer ticks every cycle;
    // a count read clears the flag, but an underflow on the same edge
    // sets it again so the interrupt is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PRESCALED;
            count <= 8'h00;
            pre   <= 10'd1023;
            sel_q <= SEL_RESET;
            ien   <= 1'b0;
        end else if (wr) begin
            state <= PRESCALED;
            count <= din;
            pre   <= prescale_reload(sel);
            sel_q <= sel;
            ien   <= ie;
        end else begin
            if (rd) begin
                ien <= ie;
            end
            case (state)
                PRESCALED: begin
                    if (pre != 10'd0) begin
                        pre <= pre - 10'd1;
                    end else begin
                        pre   <= prescale_reload(sel_q);
                        count <= count - 8'd1;
                        if (count == 8'h00) begin
                            state <= FAST;
                        end
                    end
                end
                FAST: begin
                    count <= count - 8'd1;
                    if (rd) begin
                        state <= PRESCALED;
                    end
                end
                default: state <= PRESCALED;
            endcase
        end
    end

    assign flag = (state == FAST);

endmodule

// File: rtl/riot.sv
// riot: bus-side RAM / I/O / timer responder for the mpu bus.
// Ports:
//   CLK, RES_N         : clock, asynchronous active-low reset
//   CS, RS_N, R_W, A   : chip select, RAM/register select, read/write, address
//   DB_IN, DB_OUT      : write data in, combinational read data out
//   PA_IN, PB_IN       : port pin inputs
//   PA_OUT, PB_OUT     : output registers ORA/ORB
//   PA_OE, PB_OE       : data direction registers DDRA/DDRB (1 = output)
//   IRQ_N              : active-low timer interrupt
module riot #(
    parameter int RAM_DEPTH = 7
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic       CS,
    input  logic       RS_N,
    input  logic       R_W,
    input  logic [6:0] A,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    input  logic [7:0] PA_IN,
    input  logic [7:0] PB_IN,
    output logic [7:0] PA_OUT,
    output logic [7:0] PB_OUT,
    output logic [7:0] PA_OE,
    output logic [7:0] PB_OE,
    output logic       IRQ_N
);
    import riot_pkg::*;

    logic [7:0] ram [2**RAM_DEPTH];
    logic [7:0] ora, ddra, orb, ddrb;
    logic [7:0] timer_count;
    logic       timer_flag, timer_ien;
    logic       wr_en, rd_en, ram_wr, port_wr, timer_wr, timer_rd;

    assign wr_en    = CS & ~R_W;
    assign rd_en    = CS & R_W;
    assign ram_wr   = wr_en & ~RS_N;
    assign port_wr  = wr_en & RS_N & ~A[TIMER_BIT];
    assign timer_wr = wr_en & RS_N & A[TIMER_BIT];
    assign timer_rd = rd_en & RS_N & A[TIMER_BIT] & ~A[FLAG_BIT];

    // Scratch RAM is deliberately not reset
    always_ff @(posedge CLK) begin
        if (ram_wr) begin
            ram[A[RAM_DEPTH-1:0]] <= DB_IN;
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            ora  <= 8'h00;
            ddra <= 8'h00;
            orb  <= 8'h00;
            ddrb <= 8'h00;
        end else if (port_wr) begin
            case (A[1:0])
                ORA:     ora  <= DB_IN;
                DDRA:    ddra <= DB_IN;
                ORB:     orb  <= DB_IN;
                default: ddrb <= DB_IN;
            endcase
        end
    end

    riot_timer u_timer (
        .clk   (CLK),
        .rst_n (RES_N),
        .wr    (timer_wr),
        .rd    (timer_rd),
        .din   (DB_IN),
        .sel   (A[1:0]),
        .ie    (A[IE_BIT]),
        .count (timer_count),
        .flag  (timer_flag),
        .ien   (timer_ien)
    );

    // Port reads merge pin inputs (input bits) with the output register
    // (output bits), so software sees what is actually on each pin.
    always_comb begin
        DB_OUT = 8'h00;
        if (CS) begin
            if (!RS_N) begin
                DB_OUT = ram[A[RAM_DEPTH-1:0]];
            end else if (!A[TIMER_BIT]) begin
                case (A[1:0])
                    ORA:     DB_OUT = (PA_IN & ~ddra) | (ora & ddra);
                    DDRA:    DB_OUT = ddra;
                    ORB:     DB_OUT = (PB_IN & ~ddrb) | (orb & ddrb);
                    default: DB_OUT = ddrb;
                endcase
            end else if (A[FLAG_BIT]) begin
                DB_OUT = {timer_flag, 7'b0};
            end else begin
                DB_OUT = timer_count;
            end
        end
    end

    assign PA_OUT = ora;
    assign PB_OUT = orb;
    assign PA_OE  = ddra;
    assign PB_OE  = ddrb;
    assign IRQ_N  = ~(timer_flag & timer_ien);

endmodule

// File: doc/riot.md
# riot

Bus-side RAM/I/O/timer responder for the `mpu` bus. The block answers MPU reads and writes with 128 bytes of scratch RAM, two 8-bit bidirectional I/O ports with data-direction registers, and a prescaled 8-bit interval timer with an interrupt output. It sits beside `memory` on the shared bus. An external decoder supplies `CS` from `ABH`/`ABL`. Read data is combinational from the current address, so the MPU samples it exactly as it samples `memory`.

## Interface
- `RAM_DEPTH`, default 7: address bits of the scratch RAM (128 bytes).
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RES_N` in 1: reset, asynchronous, active-low.
- `CS` in 1: chip select from the external address decoder.
- `RS_N` in 1: 0 selects RAM, 1 selects the registers.
- `R_W` in 1: MPU read/write strobe; 1 = read, 0 = write.
- `A` in 7: `ABL[6:0]`.
- `DB_IN` in 8: write data, driven from MPU `DB_OUT`.
- `DB_OUT` out 8: read data, driven to MPU `DB_IN`.
- `PA_IN`, `PB_IN` in 8 each: port pin inputs.
- `PA_OUT`, `PB_OUT` out 8 each: output registers ORA and ORB.
- `PA_OE`, `PB_OE` out 8 each: DDRA and DDRB; a bit value of 1 means that pin is an output.
- `IRQ_N` out 1: active-low interrupt, equal to ~(TFLAG & TIE).

## Operation
- Write strobe: `CS & ~R_W`, committed on the rising edge. Read side effects: `CS & R_W`, applied on the rising edge.
- Address map with `RS_N=0`:
  - `RAM[A]` is read and written.
  - RAM is not reset.
- Address map with `RS_N=1, A[2]=0`, where `A[1:0]` selects:
  - 0 selects ORA.
  - 1 selects DDRA.
  - 2 selects ORB.
  - 3 selects DDRB.
  - Port read value: (P*_IN & ~DDR) | (OR & DDR).
- Address map with `RS_N=1, A[2]=1`, write:
  - TIMER <= `DB_IN`.
  - SEL <= `A[1:0]`, giving an interval of 1, 8, 64 or 1024.
  - TIE <= `A[3]`.
  - PRE <= interval−1; TFLAG <= 0.
- Address map with `RS_N=1, A[2]=1`, read:
  - `A[0]=0` returns TIMER, clears TFLAG and sets TIE <= `A[3]`.
  - `A[0]=1` returns {TFLAG, 7'b0} with no side effect.
- Timer states, run every cycle when no timer write is taking place:
  - PRESCALED (TFLAG=0): if PRE≠0 then PRE−1. Otherwise PRE <= interval−1 and TIMER−1. If TIMER was 0x00 at that tick, TIMER <= 0xFF, TFLAG <= 1 and the state moves to FAST.
  - FAST (TFLAG=1): TIMER decrements by 1 every cycle, wrapping 0x00→0xFF, until a timer read or write clears TFLAG.
- Precedence:
  - A timer write beats decrement and underflow in the same cycle.
  - A timer read in the same cycle as an underflow leaves TFLAG=1, because the set wins and the interrupt is not lost.
- `DB_OUT` is 0x00 when `CS=0`.
- Arithmetic is modulo 2^8 for TIMER and modulo 2^10 for PRE.

## Timing
- Read latency is 0 cycles; `DB_OUT` is combinational from `CS`/`RS_N`/`A`/state. Writes are visible one edge later.
- With interval N and loaded value D, TFLAG rises at edge (D+1)·N after the write edge. `IRQ_N` falls combinationally once TFLAG and TIE are both 1.
- Reset values:
  - ORA, ORB, DDRA, DDRB = 0x00.
  - TIMER = 0x00, SEL = 1024, PRE = 1023.
  - TFLAG = 0, TIE = 0, hence `IRQ_N` = 1.
  - `PA_*`/`PB_*` outputs = 0x00.
- Reset mid-count aborts immediately, because reset is asynchronous.

## Structure
- `riot_pkg` holds:
  - Register offset constants: `ORA`, `DDRA`, `ORB`, `DDRB`.
  - Timer/flag select bits.
  - The prescale interval table (1/8/64/1024).
- Sub-module `riot_timer` holds TIMER, PRE, SEL, TFLAG and TIE.
  - Inputs: `wr`, `rd`, `din`, `sel`, `ie`.
  - Outputs: `count`, `flag`.
- The top level holds the RAM, the port registers and the read mux.

## Test plan
- Reset: pulse `RES_N` low. Then `IRQ_N`=1, `PA_OE`=`PB_OE`=0x00, and a timer read returns 0x00.
- RAM: write 0xA5 to RAM 0x7F and 0x3C to RAM 0x00. Read-back returns 0xA5 and 0x3C, and port/timer state is unchanged.
- Ports:
  - Setup: DDRA=0x0F, ORA=0x55, `PA_IN`=0xA0.
  - Required: `PA_OUT`=0x55, `PA_OE`=0x0F, and a read of ORA returns 0xA5.
- Timer ÷8:
  - Setup: write 0x02 with `A[1:0]`=01 and `A[3]`=1.
  - Required: TFLAG and `IRQ_N`=0 exactly 24 edges later, with TIMER=0xFF. The next cycles read 0xFE, then 0xFD.
  - A timer read then gives `IRQ_N`=1 and resumes ÷8 decrement.
- Flag-only read: after underflow with TIE=0, `IRQ_N` stays 1. A read at `A[0]`=1 returns 0x80 and the flag remains set.
- Collisions:
  - A timer write on the underflow edge loads the new value with TFLAG=0.
  - A timer read on the underflow edge leaves TFLAG=1.
